ap_ctrl_driver: RTL and testbench
=================================

Name: ap_ctrl_driver

Overview:
- Synthesizable initiator for the HLS block-level ap_ctrl_hs/ap_ctrl_chain handshake. It drives ap_start and ap_continue and consumes ap_ready, ap_done and ap_idle; it is the active counterpart of the passive module-status monitors.
- Launches a commanded number of kernel transactions, allowing several in flight, and measures per-transaction latency.
- Flags protocol errors and timeouts.
- Sits between a control/CSR block and an HLS kernel top (e.g. the fetch/decode IP) in standalone self-test harnesses.

Parameters:
- CNT_W, 32, width of counts, timestamps and latencies.
- MAX_OUTSTANDING, 4, maximum transactions accepted (ap_ready seen) but not yet done; power of 2, at least 1.
- TIMEOUT, 100000, cycles without progress before the watchdog fires; 0 disables the watchdog.
- USE_CONTINUE, 1, 1 = ap_ctrl_chain (drive ap_continue), 0 = ap_ctrl_hs (ap_continue tied 1).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_W  number of transactions to launch.
- abort  in  1  kill the current command.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted the start.
- ap_done  in  1  kernel finished one transaction.
- ap_idle  in  1  kernel idle; reported only.
- ap_continue  out  1  kernel continue.
- busy  out  1  state is ISSUE or DRAIN.
- done_pulse  out  1  one-cycle pulse when the command completes.
- txn_started  out  CNT_W  accepted starts in the current command.
- txn_done  out  CNT_W  completions in the current command.
- last_latency  out  CNT_W  latency of the most recent completion.
- max_latency  out  CNT_W  maximum latency in the current command.
- timeout_err  out  1  sticky watchdog error.
- proto_err  out  1  sticky protocol error.
- kernel_idle  out  1  registered copy of ap_idle.

Behaviour:
- Reset (asynchronous assert): state IDLE; all counters, latencies, flags, ap_start, done_pulse, busy = 0; cmd_ready = 1; ap_continue = 0 if USE_CONTINUE = 1, else 1; ts_fifo empty; timestamp counter = 0.
- Free-running timestamp counter increments every cycle and wraps. Latency = (ts_done − ts_accept + 1) mod 2^CNT_W.
- State IDLE:
  - Command accept = cmd_valid & cmd_ready.
  - On accept: clear txn_started, txn_done, last_latency, max_latency, timeout_err, proto_err; load remaining = cmd_count.
  - cmd_count = 0: remain in IDLE; done_pulse asserts on the next cycle.
  - cmd_count > 0: go to ISSUE.
- State ISSUE:
  - ap_start = (remaining > 0) & (outstanding < MAX_OUTSTANDING), where outstanding = fifo occupancy.
  - On the cycle ap_start & ap_ready: remaining−1, txn_started+1, push current timestamp.
  - ap_start may remain high back-to-back for pipelined kernels.
  - When remaining reaches 0, go to DRAIN on the next cycle.
- ap_done handling (ISSUE or DRAIN):
  - Pop the head timestamp; txn_done+1; update last_latency and max_latency (registered, 1-cycle latency).
  - Same-cycle handshake and done with an empty fifo: bypass, latency = 1.
  - Same-cycle push and pop with a non-empty fifo: occupancy unchanged.
- State DRAIN: ap_start = 0. When outstanding = 0 (and no push pending), go to IDLE and pulse done_pulse for one cycle.
- ap_continue (USE_CONTINUE = 1): 1 in ISSUE and DRAIN, 0 in IDLE and ERROR.
- Protocol error: ap_done with outstanding = 0 and no same-cycle handshake, or ap_done in IDLE.
  - Set proto_err; ignore the event (no counter change).
- Watchdog: counts cycles while outstanding > 0 or ap_start = 1. It clears on any handshake or ap_done. When it reaches TIMEOUT: go to ERROR, set timeout_err, drive ap_start = 0 and busy = 0.
- State ERROR: exits only via abort, going to IDLE; cmd_ready = 0 while in ERROR.
- abort (any state, highest priority):
  - Next state IDLE; ap_start drops on the next cycle even without ap_ready (deliberate kill; the kernel is reset externally).
  - Flush the fifo; no done_pulse; counters and flags hold their values.
- Reset mid-operation: immediate return to reset values.

Decomposition:
- Package ap_ctrl_driver_pkg:
  - state_e {IDLE, ISSUE, DRAIN, ERROR}.
  - Latency/timestamp typedef parameterized via CNT_W.
  - Localparam for the fifo pointer width, $clog2(MAX_OUTSTANDING).
- One sub-module, ts_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width CNT_W.
  - Ports: push, pop, flush, full, empty, count, head.
  - Same-cycle push/pop allowed when not empty.

Test Plan:
1. cmd_count = 3, kernel with ready on start and done exactly 10 cycles after the handshake, one in flight at a time -> txn_started = 3, txn_done = 3, last_latency = max_latency = 11, one done_pulse, proto_err = 0.
2. cmd_count = 8, pipelined kernel (ready every cycle, done 5 cycles later), MAX_OUTSTANDING = 4 -> outstanding never exceeds 4, ap_start stalls when 4 are in flight, all latencies = 6, txn_done = 8.
3. cmd_count = 0 -> no ap_start, done_pulse on the cycle after accept, cmd_ready stays 1.
4. Combinational kernel (ap_ready = ap_done = ap_start same cycle), cmd_count = 2 -> latency = 1 via bypass, fifo never non-empty.
5. TIMEOUT = 50, kernel never asserts ap_done after the handshake -> ERROR at cycle 50 after the handshake, timeout_err = 1, ap_start = 0; abort -> IDLE, cmd_ready = 1.
6. Spurious ap_done in IDLE -> proto_err = 1, txn_done stays 0. Reset asserted mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ap_ctrl_driver_pkg.sv
// Shared types and sizing helpers for the ap_ctrl_hs/ap_ctrl_chain initiator.
package ap_ctrl_driver_pkg;

    localparam int DEF_CNT_W           = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int PTR_W               = $clog2(DEF_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ERROR = 2'd3
    } state_e;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // A depth-1 fifo still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ap_ctrl_driver_ts_fifo.sv
// Timestamp fifo holding the accept time of every transaction still in flight.
module ap_ctrl_driver_ts_fifo
    import ap_ctrl_driver_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTSTANDING,
    parameter int WIDTH = DEF_CNT_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [OW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign full    = (cnt_q == OW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Initiator for the HLS ap_ctrl_hs/ap_ctrl_chain handshake: launches a counted
// burst of kernel transactions, measures their latency and watches for errors.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   ISSUE | driving ap_start until every commanded start is accepted
//   DRAIN | starts done, waiting for outstanding completions
//   ERROR | watchdog fired, only abort leaves
module ap_ctrl_driver
    import ap_ctrl_driver_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TIMEOUT         = 100000,
    parameter bit USE_CONTINUE    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             ap_continue,
    output logic             busy,
    output logic             done_pulse,
    output logic [CNT_W-1:0] txn_started,
    output logic [CNT_W-1:0] txn_done,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic             timeout_err,
    output logic             proto_err,
    output logic             kernel_idle
);

    localparam int               OCC_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ts_q;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] started_q, started_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;
    logic [CNT_W-1:0] max_lat_q, max_lat_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             start_q, start_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             cont_q, cont_d;
    logic             pulse_q, pulse_d;
    logic             tmo_q, tmo_d;
    logic             proto_q, proto_d;
    logic             kidle_q;

    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] occ, occ_d;
    logic [CNT_W-1:0] head;
    logic             active, hs, done_ok, bypass, push, pop, proto_ev;
    logic             accept, wd_active, progress, wd_fire;
    logic [CNT_W-1:0] lat;

    ap_ctrl_driver_ts_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CNT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .din   (ts_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ),
        .head  (head)
    );

    assign active   = (state_q == ISSUE) || (state_q == DRAIN);
    assign hs       = start_q & ap_ready & ~abort;
    assign done_ok  = ap_done & active & (~fifo_empty | hs) & ~abort;
    assign bypass   = done_ok & fifo_empty;
    assign pop      = done_ok & ~fifo_empty;
    assign push     = hs & ~bypass & (~fifo_full | pop);
    assign proto_ev = ap_done & ~abort &
                      ((state_q == IDLE) || (active && fifo_empty && !hs));
    assign accept   = cmd_valid & cmd_ready_q & (state_q == IDLE) & ~abort;
    assign lat      = bypass ? CNT_W'(1) : (ts_q - head + CNT_W'(1));

    // Watchdog is a down-counter reloaded on any progress; it fires on reaching zero.
    assign wd_active = WD_EN && active && ((occ != '0) || start_q);
    assign progress  = hs | ap_done;
    assign wd_fire   = wd_active && !progress && !abort && (wd_q == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        started_d  = started_q;
        done_d     = done_q;
        last_lat_d = last_lat_q;
        max_lat_d  = max_lat_q;
        tmo_d      = tmo_q;
        proto_d    = proto_q;
        pulse_d    = 1'b0;
        wd_d       = (!wd_active || progress) ? WD_LOAD : (wd_q - 1'b1);
        occ_d      = occ;

        if (abort) begin
            state_d = IDLE;
            wd_d    = WD_LOAD;
            occ_d   = '0;
        end else begin
            if (push && !pop)      occ_d = occ + 1'b1;
            else if (pop && !push) occ_d = occ - 1'b1;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        started_d  = '0;
                        done_d     = '0;
                        last_lat_d = '0;
                        max_lat_d  = '0;
                        tmo_d      = 1'b0;
                        proto_d    = 1'b0;
                        rem_d      = cmd_count;
                        if (cmd_count == '0) pulse_d = 1'b1;
                        else                 state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        rem_d     = rem_q - 1'b1;
                        started_d = started_q + 1'b1;
                    end
                    if (rem_d == '0) state_d = DRAIN;
                end
                DRAIN: begin
                    if (occ == '0 && !push) begin
                        state_d = IDLE;
                        pulse_d = 1'b1;
                    end
                end
                default: ;
            endcase

            if (done_ok) begin
                done_d     = done_q + 1'b1;
                last_lat_d = lat;
                if (lat > max_lat_q) max_lat_d = lat;
            end
            if (proto_ev) proto_d = 1'b1;
            if (wd_fire) begin
                state_d = ERROR;
                tmo_d   = 1'b1;
                pulse_d = 1'b0;
            end
        end

        start_d     = (state_d == ISSUE) && (rem_d != '0) && (occ_d < OCC_MAX);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
        cont_d      = USE_CONTINUE ? busy_d : 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            rem_q       <= '0;
            started_q   <= '0;
            done_q      <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            wd_q        <= WD_LOAD;
            start_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cont_q      <= !USE_CONTINUE;
            pulse_q     <= 1'b0;
            tmo_q       <= 1'b0;
            proto_q     <= 1'b0;
            kidle_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 1'b1;
            rem_q       <= rem_d;
            started_q   <= started_d;
            done_q      <= done_d;
            last_lat_q  <= last_lat_d;
            max_lat_q   <= max_lat_d;
            wd_q        <= wd_d;
            start_q     <= start_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cont_q      <= cont_d;
            pulse_q     <= pulse_d;
            tmo_q       <= tmo_d;
            proto_q     <= proto_d;
            kidle_q     <= ap_idle;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign ap_start     = start_q;
    assign ap_continue  = cont_q;
    assign busy         = busy_q;
    assign done_pulse   = pulse_q;
    assign txn_started  = started_q;
    assign txn_done     = done_q;
    assign last_latency = last_lat_q;
    assign max_latency  = max_lat_q;
    assign timeout_err  = tmo_q;
    assign proto_err    = proto_q;
    assign kernel_idle  = kidle_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver with a small behavioural HLS kernel model.
module tb_ap_ctrl_driver;

    localparam int CNT_W = 32;
    localparam int MAXO  = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             abort = 1'b0;
    logic             ap_idle = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_ready, ap_start, ap_ready, ap_done, ap_continue;
    logic             busy, done_pulse, timeout_err, proto_err, kernel_idle;
    logic [CNT_W-1:0] txn_started, txn_done, last_latency, max_latency;

    // kernel model controls
    bit          single = 1'b0;
    bit          comb = 1'b0;
    bit          ready_en = 1'b1;
    bit          done_en = 1'b1;
    bit          force_done = 1'b0;
    int          lidx = 0;
    logic [63:0] lat_mask = '0;
    logic [63:0] pipe;

    int checks = 0;
    int errors = 0;

    ap_ctrl_driver #(
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT         (50),
        .USE_CONTINUE    (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .abort        (abort),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .txn_started  (txn_started),
        .txn_done     (txn_done),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .timeout_err  (timeout_err),
        .proto_err    (proto_err),
        .kernel_idle  (kernel_idle)
    );

    always #5 clock = ~clock;

    // Kernel: single mode accepts only when nothing is pending; done follows the
    // handshake by lidx+1 edges (latency lidx+2), or same cycle in comb mode.
    assign ap_ready = ap_start & ready_en & (!single | ((pipe & lat_mask) == 64'd0));
    assign ap_done  = force_done | (comb ? (ap_start & ap_ready) : (done_en & pipe[lidx]));

    always @(posedge clock or posedge reset) begin
        if (reset) pipe <= '0;
        else       pipe <= {pipe[62:0], ap_start & ap_ready & !comb};
    end

    // Independent outstanding/latency bookkeeping.
    int  model_out, peak, starts_seen;
    bit  stall_seen, dn_flag, clr;
    logic [CNT_W-1:0] lat_min, lat_max;
    bit  lat_seen;

    always @(posedge clock) begin
        if (reset || clr) begin
            model_out = 0; peak = 0; starts_seen = 0; stall_seen = 0; dn_flag = 0;
        end else begin
            if (busy && !ap_start && model_out == MAXO) stall_seen = 1;
            if (ap_start && ap_ready) begin model_out++; starts_seen++; end
            dn_flag = ap_done && !force_done;
            if (dn_flag) model_out--;
            if (model_out > peak) peak = model_out;
        end
    end

    always @(negedge clock) begin
        if (clr) begin
            lat_seen = 0; lat_min = '0; lat_max = '0;
        end else if (dn_flag) begin
            if (!lat_seen || last_latency < lat_min) lat_min = last_latency;
            if (!lat_seen || last_latency > lat_max) lat_max = last_latency;
            lat_seen = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        @(negedge clock); clr = 1;
        @(negedge clock); clr = 0;
    endtask

    task automatic run_cmd(input int cnt, output int pulses);
        pulses = 0;
        @(negedge clock); cmd_count = cnt; cmd_valid = 1;
        @(negedge clock); cmd_valid = 0;
        for (int i = 0; i < 3000 && pulses == 0; i++) begin
            if (done_pulse) pulses++;
            else @(negedge clock);
        end
        repeat (6) begin
            @(negedge clock);
            if (done_pulse) pulses++;
        end
    endtask

    task automatic wait_hs(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ap_start && ap_ready) found = 1;
            else @(negedge clock);
        end
        chk(name, found, 1);
    endtask

    typedef struct {
        int cnt;
        bit single;
        bit comb;
        int lidx;
        int e_started;
        int e_done;
        int e_lat;
        int e_pulses;
        int e_peak;
        bit e_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int pulses;
        bit  pulse_seen;

        vecs[0] = '{3, 1'b1, 1'b0, 9, 3, 3, 11, 1, 1, 1'b0};
        vecs[1] = '{8, 1'b0, 1'b0, 4, 8, 8,  6, 1, 4, 1'b1};
        vecs[2] = '{0, 1'b0, 1'b0, 4, 0, 0,  0, 1, 0, 1'b0};
        vecs[3] = '{2, 1'b0, 1'b1, 0, 2, 2,  1, 1, 0, 1'b0};
        vecs[4] = '{5, 1'b0, 1'b0, 0, 5, 5,  2, 1, 1, 1'b0};
        vecs[5] = '{4, 1'b1, 1'b0, 2, 4, 4,  4, 1, 1, 1'b0};

        clr = 0;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready",   cmd_ready, 1);
        chk("rst_ap_start",    ap_start, 0);
        chk("rst_busy",        busy, 0);
        chk("rst_done_pulse",  done_pulse, 0);
        chk("rst_ap_continue", ap_continue, 0);
        chk("rst_txn_started", txn_started, 0);
        chk("rst_latency",     max_latency, 0);
        chk("rst_errs",        {timeout_err, proto_err}, 0);
        reset = 0;
        ap_idle = 1;
        @(negedge clock);
        chk("kernel_idle", kernel_idle, 1);

        for (int v = 0; v < 6; v++) begin
            single = vecs[v].single;
            comb   = vecs[v].comb;
            lidx   = vecs[v].lidx;
            lat_mask = (64'd1 << (vecs[v].lidx + 1)) - 64'd1;
            ready_en = 1; done_en = 1;
            clear_stats();
            run_cmd(vecs[v].cnt, pulses);
            $display("vector %0d cnt=%0d", v, vecs[v].cnt);
            chk("txn_started",  txn_started, vecs[v].e_started);
            chk("txn_done",     txn_done, vecs[v].e_done);
            chk("last_latency", last_latency, vecs[v].e_lat);
            chk("max_latency",  max_latency, vecs[v].e_lat);
            chk("lat_min_seen", lat_min, vecs[v].e_lat);
            chk("lat_max_seen", lat_max, vecs[v].e_lat);
            chk("done_pulses",  pulses, vecs[v].e_pulses);
            chk("starts_seen",  starts_seen, vecs[v].e_started);
            chk("peak_outst",   peak, vecs[v].e_peak);
            chk("stall_seen",   stall_seen, vecs[v].e_stall);
            chk("proto_err",    proto_err, 0);
            chk("end_cmd_rdy",  cmd_ready, 1);
        end

        // Watchdog: kernel accepts but never completes.
        single = 1; comb = 0; lidx = 9; lat_mask = 64'h3ff; done_en = 0; ready_en = 1;
        @(negedge clock); cmd_count = 1; cmd_valid = 1;
        @(negedge clock); cmd_valid = 0;
        wait_hs("tmo_hs_seen");
        @(posedge clock);
        repeat (49) @(posedge clock);
        #1;
        chk("tmo_not_yet",   timeout_err, 0);
        chk("tmo_busy_pre",  busy, 1);
        chk("tmo_cont_pre",  ap_continue, 1);
        @(posedge clock);
        #1;
        chk("tmo_err",       timeout_err, 1);
        chk("tmo_busy",      busy, 0);
        chk("tmo_ap_start",  ap_start, 0);
        chk("tmo_cmd_ready", cmd_ready, 0);
        chk("tmo_cont",      ap_continue, 0);
        @(negedge clock); abort = 1;
        @(negedge clock); abort = 0;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_tmo_hold",  timeout_err, 1);
        chk("abort_started",   txn_started, 1);

        // Reset in the middle of DRAIN.
        done_en = 1;
        @(negedge clock); cmd_count = 1; cmd_valid = 1;
        @(negedge clock); cmd_valid = 0;
        wait_hs("drain_hs_seen");
        @(posedge clock);
        @(negedge clock);
        chk("drain_busy", busy, 1);
        reset = 1;
        #1;
        chk("mid_rst_busy",    busy, 0);
        chk("mid_rst_started", txn_started, 0);
        chk("mid_rst_ready",   cmd_ready, 1);
        chk("mid_rst_cont",    ap_continue, 0);
        chk("mid_rst_flags",   {ap_start, done_pulse, timeout_err}, 0);
        @(negedge clock); reset = 0;

        // Spurious ap_done while idle.
        @(negedge clock); force_done = 1;
        @(negedge clock); force_done = 0;
        chk("idle_proto",    proto_err, 1);
        chk("idle_txn_done", txn_done, 0);

        // ap_done with nothing outstanding while issuing, then abort.
        ready_en = 0; single = 0;
        @(negedge clock); cmd_count = 5; cmd_valid = 1;
        @(negedge clock); cmd_valid = 0;
        chk("accept_clr_proto", proto_err, 0);
        force_done = 1;
        @(negedge clock); force_done = 0;
        chk("issue_proto",    proto_err, 1);
        chk("issue_txn_done", txn_done, 0);
        chk("issue_busy",     busy, 1);
        @(negedge clock); abort = 1;
        @(negedge clock); abort = 0;
        pulse_seen = done_pulse;
        repeat (4) begin
            @(negedge clock);
            if (done_pulse) pulse_seen = 1;
        end
        chk("abort_no_pulse",   pulse_seen, 0);
        chk("abort_ap_start",   ap_start, 0);
        chk("abort_ready2",     cmd_ready, 1);
        chk("abort_proto_hold", proto_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
